// File: rtl/nonce_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nonce_search_ctrl
// Description : Sequences a nonce search against an external hash engine.
//               Each try launches the engine with the current nonce, waits
//               for its completion pulse, then checks both upper hash bytes
//               against the captured difficulty target. It stops on the first
//               valid hash (fin) or after MAX_TRIES invalid hashes (fail).
// Ports       : clk, reset_L (async active-low)
//               start, abort          - search control
//               target, nonce_base    - search setup, captured on start
//               hash_start/hash_nonce - engine launch side
//               hash_done/hash_out    - engine completion side
//               busy, fin, fail       - status
//               nonce_valido_out, bounty_out - winning nonce and hash
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_search_ctrl #(
    parameter logic [31:0] MAX_TRIES = 32'd65536
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  target,
    input  logic [31:0] nonce_base,
    output logic        hash_start,
    output logic [31:0] hash_nonce,
    input  logic        hash_done,
    input  logic [23:0] hash_out,
    output logic        busy,
    output logic        fin,
    output logic        fail,
    output logic [31:0] nonce_valido_out,
    output logic [23:0] bounty_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  target_q,    target_d;
    logic [31:0] nonce_q,     nonce_d;
    logic [31:0] tries_q,     tries_d;
    logic [23:0] hash_q,      hash_d;
    logic [31:0] win_nonce_q, win_nonce_d;
    logic [23:0] win_hash_q,  win_hash_d;

    logic        w_hash_ok;

    // Both upper bytes must be strictly below the target; equal is a miss.
    assign w_hash_ok = (hash_q[23:16] < target_q) && (hash_q[15:8] < target_q);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= S_IDLE;
            target_q    <= 8'd0;
            nonce_q     <= 32'd0;
            tries_q     <= 32'd0;
            hash_q      <= 24'd0;
            win_nonce_q <= 32'd0;
            win_hash_q  <= 24'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            tries_q     <= tries_d;
            hash_q      <= hash_d;
            win_nonce_q <= win_nonce_d;
            win_hash_q  <= win_hash_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        tries_d     = tries_q;
        hash_d      = hash_q;
        win_nonce_d = win_nonce_q;
        win_hash_d  = win_hash_q;
        hash_start  = 1'b0;

        if (abort) begin
            // Abort wins over start and hash_done; the launch pulse is
            // suppressed so the engine never sees a request we then drop.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_d  = S_LAUNCH;
                        target_d = target;
                        nonce_d  = nonce_base;
                        tries_d  = 32'd0;
                    end
                end
                S_LAUNCH: begin
                    hash_start = 1'b1;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (hash_done) begin
                        hash_d  = hash_out;
                        tries_d = tries_q + 32'd1;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Validity is judged before exhaustion, so a hit on the
                    // final allowed try still completes successfully.
                    if (w_hash_ok) begin
                        win_nonce_d = nonce_q;
                        win_hash_d  = hash_q;
                        state_d     = S_DONE;
                    end else if (tries_q >= MAX_TRIES) begin
                        state_d = S_FAIL;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = S_LAUNCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign hash_nonce       = nonce_q;
    assign busy             = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                              (state_q == S_CHECK);
    assign fin              = (state_q == S_DONE);
    assign fail             = (state_q == S_FAIL);
    assign nonce_valido_out = win_nonce_q;
    assign bounty_out       = win_hash_q;

endmodule
`default_nettype wire
